vdp18_pat_fetch: RTL and testbench

VDP18_PAT_FETCH -- requirements
Module: vdp18_pat_fetch

---
 rtl/vdp18_pkg.sv | 54 +++++
 rtl/vdp18_pat_fetch_if.sv | 22 ++
 rtl/vdp18_pat_addr.sv | 47 ++++
 rtl/vdp18_pat_fetch.sv | 111 +++++++++++
 tb/tb_vdp18_pat_fetch.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vdp18_pkg.sv
// Shared types for the VDP18 pattern fetch: VRAM access kinds, display modes
// and the per-mode slot sequences of one fetch cell.
package vdp18_pkg;

  typedef enum logic [1:0] {
    OPMODE_GRAPH1 = 2'd0,
    OPMODE_GRAPH2 = 2'd1,
    OPMODE_MULTIC = 2'd2,
    OPMODE_TEXTM  = 2'd3
  } opmode_t;

  typedef enum logic [2:0] {
    AC_NONE = 3'd0,
    AC_PNT  = 3'd1,
    AC_PCT  = 3'd2,
    AC_PGT  = 3'd3,
    AC_CPU  = 3'd4
  } access_t;

  localparam int unsigned SEQ_LEN_GRAPH  = 4;
  localparam int unsigned SEQ_LEN_TEXTM  = 3;
  localparam int unsigned SEQ_LEN_MULTIC = 4;

  function automatic logic [1:0] seq_last_slot(input opmode_t mode);
    case (mode)
      OPMODE_TEXTM:  seq_last_slot = 2'(SEQ_LEN_TEXTM - 1);
      OPMODE_MULTIC: seq_last_slot = 2'(SEQ_LEN_MULTIC - 1);
      default:       seq_last_slot = 2'(SEQ_LEN_GRAPH - 1);
    endcase
  endfunction

  // AC_CPU here marks a CPU slot; the sequencer demotes it to AC_NONE when idle.
  function automatic access_t seq_slot_type(input opmode_t mode, input logic [1:0] slot);
    seq_slot_type = AC_CPU;
    case (mode)
      OPMODE_TEXTM, OPMODE_MULTIC: begin
        case (slot)
          2'd0:    seq_slot_type = AC_PNT;
          2'd1:    seq_slot_type = AC_PGT;
          default: seq_slot_type = AC_CPU;
        endcase
      end
      default: begin
        case (slot)
          2'd0:    seq_slot_type = AC_PNT;
          2'd1:    seq_slot_type = AC_PCT;
          2'd2:    seq_slot_type = AC_PGT;
          default: seq_slot_type = AC_CPU;
        endcase
      end
    endcase
  endfunction

endpackage

// File: rtl/vdp18_pat_fetch_if.sv
// CPU request/grant handshake and VRAM access bus of the pattern fetch.
// slave = fetch unit, master = CPU requester / VRAM side.
interface vdp18_pat_fetch_if;
  import vdp18_pkg::*;

  logic        cpu_req_i;
  logic [13:0] cpu_addr_i;
  logic        cpu_ack_o;
  access_t     access_type_o;
  logic [13:0] vram_a_o;
  logic        vram_ce_o;

  modport master (
    output cpu_req_i, cpu_addr_i,
    input  cpu_ack_o, access_type_o, vram_a_o, vram_ce_o
  );

  modport slave (
    input  cpu_req_i, cpu_addr_i,
    output cpu_ack_o, access_type_o, vram_a_o, vram_ce_o
  );
endinterface

// File: rtl/vdp18_pat_addr.sv
// Combinational VRAM address formation for the registered slot type.
// Vectors are descending; bit 0 of the original MSB-first numbering is the MSB here.
module vdp18_pat_addr
  import vdp18_pkg::*;
(
  input  access_t           access_i,
  input  opmode_t           opmode_i,
  input  logic signed [8:0] num_line_i,
  input  logic [3:0]        reg_ntb_i,
  input  logic [7:0]        reg_ctb_i,
  input  logic [2:0]        reg_pgb_i,
  input  logic [9:0]        pat_table_i,
  input  logic [7:0]        pat_name_i,
  input  logic [13:0]       cpu_addr_i,
  output logic [13:0]       vram_a_o
);

  logic [12:0] g2_idx;
  logic        unused_line_bits;

  // GRAPH2 splits the screen in thirds: line MSBs select the table third.
  assign g2_idx = {num_line_i[7:6], pat_name_i, num_line_i[2:0]};
  assign unused_line_bits = ^{num_line_i[8], num_line_i[5]};

  always_comb begin
    vram_a_o = '0;
    case (access_i)
      AC_PNT: vram_a_o = {reg_ntb_i, pat_table_i};
      AC_PCT: begin
        if (opmode_i == OPMODE_GRAPH2)
          vram_a_o = {reg_ctb_i[7], g2_idx & {reg_ctb_i[6:0], 6'h3F}};
        else
          vram_a_o = {reg_ctb_i, 1'b0, pat_name_i[7:3]};
      end
      AC_PGT: begin
        case (opmode_i)
          OPMODE_GRAPH2: vram_a_o = {reg_pgb_i[2], g2_idx & {reg_pgb_i[1:0], 11'h7FF}};
          OPMODE_MULTIC: vram_a_o = {reg_pgb_i, pat_name_i, num_line_i[4:2]};
          default:       vram_a_o = {reg_pgb_i, pat_name_i, num_line_i[2:0]};
        endcase
      end
      AC_CPU:  vram_a_o = cpu_addr_i;
      default: vram_a_o = '0;
    endcase
  end

endmodule

// File: rtl/vdp18_pat_fetch.sv
// VRAM slot sequencer and CPU grant handshake for the VDP18 pattern fetch.
// Macro VDP18_MULTIC_EN enables the dedicated MULTIC sequence; otherwise MULTIC fetches as GRAPH1.
//
// slot | meaning (GRAPH1/2)  | TEXTM    | MULTIC
//   0  | PNT, latch opmode   | PNT      | PNT
//   1  | PCT                 | PGT      | PGT
//   2  | PGT                 | CPU,wrap | CPU
//   3  | CPU, wrap           | -        | CPU, wrap
module vdp18_pat_fetch
  import vdp18_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clk_en_acc_i,
  input  opmode_t           opmode_i,
  input  logic signed [8:0] num_line_i,
  input  logic              hor_active_i,
  input  logic [3:0]        reg_ntb_i,
  input  logic [7:0]        reg_ctb_i,
  input  logic [2:0]        reg_pgb_i,
  input  logic [9:0]        pat_table_i,
  input  logic [7:0]        pat_name_i,
  vdp18_pat_fetch_if.slave  bus_io
);

  localparam logic [1:0] SLOT_0 = 2'd0;

  logic [1:0]  slot_q, slot_d;
  opmode_t     opmode_q, opmode_d;
  access_t     access_q, access_d;
  logic [13:0] cpu_addr_q, cpu_addr_d;
  logic        ack_q, ack_d;
  logic        ce_q, ce_d;
  opmode_t     mode_in, mode_cell;
  access_t     slot_kind;
  logic [13:0] vram_a;

  always_comb begin
    mode_in = opmode_i;
`ifndef VDP18_MULTIC_EN
    if (opmode_i == OPMODE_MULTIC) mode_in = OPMODE_GRAPH1;
`endif
  end

  // Slot 0 already runs under the mode being latched at this edge.
  assign mode_cell = (slot_q == SLOT_0) ? mode_in : opmode_q;

  always_comb begin
    slot_d     = slot_q;
    opmode_d   = opmode_q;
    access_d   = access_q;
    cpu_addr_d = cpu_addr_q;
    ack_d      = 1'b0;
    ce_d       = 1'b0;
    slot_kind  = AC_NONE;
    if (clk_en_acc_i) begin
      if (slot_q == SLOT_0) opmode_d = mode_in;
      if (hor_active_i) begin
        slot_kind = seq_slot_type(mode_cell, slot_q);
        slot_d    = (slot_q == seq_last_slot(mode_cell)) ? SLOT_0 : slot_q + 2'd1;
      end else begin
        slot_kind = AC_CPU;
      end
      if (slot_kind == AC_CPU && !bus_io.cpu_req_i) slot_kind = AC_NONE;
      access_d = slot_kind;
      ce_d     = (slot_kind != AC_NONE);
      if (slot_kind == AC_CPU) begin
        ack_d      = 1'b1;
        cpu_addr_d = bus_io.cpu_addr_i;
      end
    end
    if (!hor_active_i) slot_d = SLOT_0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      slot_q     <= SLOT_0;
      opmode_q   <= OPMODE_GRAPH1;
      access_q   <= AC_NONE;
      cpu_addr_q <= '0;
      ack_q      <= 1'b0;
      ce_q       <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      opmode_q   <= opmode_d;
      access_q   <= access_d;
      cpu_addr_q <= cpu_addr_d;
      ack_q      <= ack_d;
      ce_q       <= ce_d;
    end
  end

  vdp18_pat_addr u_addr (
    .access_i    (access_q),
    .opmode_i    (opmode_q),
    .num_line_i  (num_line_i),
    .reg_ntb_i   (reg_ntb_i),
    .reg_ctb_i   (reg_ctb_i),
    .reg_pgb_i   (reg_pgb_i),
    .pat_table_i (pat_table_i),
    .pat_name_i  (pat_name_i),
    .cpu_addr_i  (cpu_addr_q),
    .vram_a_o    (vram_a)
  );

  assign bus_io.cpu_ack_o     = ack_q;
  assign bus_io.vram_ce_o     = ce_q;
  assign bus_io.access_type_o = access_q;
  assign bus_io.vram_a_o      = vram_a;

endmodule

// File: tb/tb_vdp18_pat_fetch.sv
// Scoreboard bench for vdp18_pat_fetch: stimulus queues expected slots, a monitor
// pops one per VRAM strobe. Expectations follow VDP18_MULTIC_EN when it is defined.
module tb_vdp18_pat_fetch;
  import vdp18_pkg::*;

  typedef struct packed {
    access_t     kind;
    logic [13:0] addr;
    logic        ack;
  } obs_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clk_en = 1'b0;
  logic              hor_active = 1'b0;
  opmode_t           opmode = OPMODE_GRAPH1;
  logic signed [8:0] num_line = '0;
  logic [3:0]        ntb = '0;
  logic [7:0]        ctb = '0;
  logic [2:0]        pgb = '0;
  logic [9:0]        pat_table = '0;
  logic [7:0]        pat_name = '0;

  vdp18_pat_fetch_if bus ();

  int   tests = 0;
  int   fails = 0;
  int   ack_cnt = 0;
  int   exp_acks = 0;
  obs_t exp_q[$];
  obs_t got, want;

  always #5 clk = ~clk;

  vdp18_pat_fetch dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .clk_en_acc_i (clk_en),
    .opmode_i     (opmode),
    .num_line_i   (num_line),
    .hor_active_i (hor_active),
    .reg_ntb_i    (ntb),
    .reg_ctb_i    (ctb),
    .reg_pgb_i    (pgb),
    .pat_table_i  (pat_table),
    .pat_name_i   (pat_name),
    .bus_io       (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_slot(input access_t kind, input logic [13:0] addr);
    exp_q.push_back({kind, addr, kind == AC_CPU});
    if (kind == AC_CPU) exp_acks++;
  endtask

  // Inputs set after this returns apply to the next rising edge; the requester drops on ack.
  task automatic step(input logic en);
    @(negedge clk);
    if (bus.cpu_ack_o) bus.cpu_req_i = 1'b0;
    clk_en = en;
  endtask

  task automatic drain(input string name);
    repeat (3) step(1'b0);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_acks"}, ack_cnt, exp_acks);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_type"}, bus.access_type_o, AC_NONE);
    check({name, "_ack"},  bus.cpu_ack_o, 1'b0);
    check({name, "_ce"},   bus.vram_ce_o, 1'b0);
    check({name, "_addr"}, bus.vram_a_o, 14'h0000);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.cpu_ack_o) ack_cnt++;
      if (bus.vram_ce_o) begin
        got = {bus.access_type_o, bus.vram_a_o, bus.cpu_ack_o};
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: got %0h, expected no strobe", got);
        end else begin
          want = exp_q.pop_front();
          check("slot", got, want);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bus.cpu_req_i  = 1'b0;
    bus.cpu_addr_i = '0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset");
    step(1'b0);
    rst = 1'b0;

    // GRAPH1 cell
    ntb = 4'h1; pat_table = 10'h005; pat_name = 8'h41; num_line = 9'sd3;
    ctb = 8'hA5; pgb = 3'b110; opmode = OPMODE_GRAPH1;
    expect_slot(AC_PNT, 14'h0405);
    expect_slot(AC_PCT, {8'hA5, 1'b0, 5'h08});
    expect_slot(AC_PGT, {3'b110, 8'h41, 3'b011});
    step(1'b1); hor_active = 1'b1;
    repeat (3) step(1'b1);
    step(1'b0); hor_active = 1'b0;
    drain("graph1");

    // CPU grant at slot 3, address held, then a request withdrawn before its slot
    bus.cpu_addr_i = 14'h3ABC;
    expect_slot(AC_PNT, 14'h0405);
    expect_slot(AC_PCT, {8'hA5, 1'b0, 5'h08});
    expect_slot(AC_PGT, {3'b110, 8'h41, 3'b011});
    expect_slot(AC_CPU, 14'h3ABC);
    step(1'b1); hor_active = 1'b1;
    step(1'b1);
    step(1'b1); bus.cpu_req_i = 1'b1;
    step(1'b1);
    step(1'b0); hor_active = 1'b0; bus.cpu_addr_i = 14'h0000;
    #1 check("cpu_addr_held", bus.vram_a_o, 14'h3ABC);
    check("cpu_req_dropped_on_ack", bus.cpu_req_i, 1'b0);
    expect_slot(AC_PNT, 14'h0405);
    expect_slot(AC_PCT, {8'hA5, 1'b0, 5'h08});
    expect_slot(AC_PGT, {3'b110, 8'h41, 3'b011});
    step(1'b1); hor_active = 1'b1;
    step(1'b1);
    step(1'b1); bus.cpu_req_i = 1'b1;
    step(1'b1); bus.cpu_req_i = 1'b0;
    step(1'b0); hor_active = 1'b0;
    drain("cpu");

    // TEXTM: period of three slots, request pending from the start
    ntb = 4'hC; pat_table = 10'h3FF; pat_name = 8'h7E; num_line = 9'sd5; pgb = 3'b010;
    bus.cpu_addr_i = 14'h1357;
    expect_slot(AC_PNT, 14'h33FF);
    expect_slot(AC_PGT, {3'b010, 8'h7E, 3'b101});
    expect_slot(AC_CPU, 14'h1357);
    expect_slot(AC_PNT, 14'h33FF);
    expect_slot(AC_PGT, {3'b010, 8'h7E, 3'b101});
    step(1'b1); hor_active = 1'b1; opmode = OPMODE_TEXTM; bus.cpu_req_i = 1'b1;
    repeat (5) step(1'b1);
    step(1'b0); hor_active = 1'b0;
    drain("textm");

    // GRAPH2 masked table addressing
    opmode = OPMODE_GRAPH2; ntb = 4'h3; pat_table = 10'h100; pat_name = 8'h00;
    num_line = 9'sd130; ctb = 8'h9F; pgb = 3'b110;
    expect_slot(AC_PNT, 14'h0D00);
    expect_slot(AC_PCT, 14'h2002);
    expect_slot(AC_PGT, 14'h3002);
    step(1'b1); hor_active = 1'b1;
    repeat (3) step(1'b1);
    step(1'b0); hor_active = 1'b0;
    drain("graph2");

    // Opmode change inside a GRAPH1 cell only applies from the next cell
    ntb = 4'h2; pat_table = 10'h010; pat_name = 8'h81; ctb = 8'h40; pgb = 3'b001; num_line = 9'sd7;
    expect_slot(AC_PNT, 14'h0810);
    expect_slot(AC_PCT, {8'h40, 1'b0, 5'b10000});
    expect_slot(AC_PGT, {3'b001, 8'h81, 3'b111});
    expect_slot(AC_PNT, 14'h0810);
    expect_slot(AC_PGT, {3'b001, 8'h81, 3'b111});
    step(1'b1); hor_active = 1'b1; opmode = OPMODE_GRAPH1;
    step(1'b1); opmode = OPMODE_TEXTM;
    repeat (5) step(1'b1);
    step(1'b0); hor_active = 1'b0;
    drain("opmode_latch");

    // Sparse slot enables, inactive CPU grant, restart at slot 0 after the gap
    opmode = OPMODE_GRAPH1; ntb = 4'h5; pat_table = 10'h0AA; pat_name = 8'hF0;
    ctb = 8'h0F; pgb = 3'b100; num_line = 9'sd2;
    expect_slot(AC_PNT, 14'h14AA);
    expect_slot(AC_PCT, {8'h0F, 1'b0, 5'b11110});
    expect_slot(AC_CPU, 14'h1234);
    expect_slot(AC_PNT, 14'h14AA);
    expect_slot(AC_PCT, {8'h0F, 1'b0, 5'b11110});
    expect_slot(AC_PGT, {3'b100, 8'hF0, 3'b010});
    step(1'b1); hor_active = 1'b1;
    step(1'b0);
    step(1'b1);
    step(1'b0);
    @(posedge clk);
    #1 check("hold_type", bus.access_type_o, AC_PCT);
    check("hold_ce", bus.vram_ce_o, 1'b0);
    step(1'b1); hor_active = 1'b0; bus.cpu_req_i = 1'b1; bus.cpu_addr_i = 14'h1234;
    step(1'b0);
    step(1'b1); hor_active = 1'b1;
    repeat (3) begin
      step(1'b0);
      step(1'b1);
    end
    step(1'b0); hor_active = 1'b0;
    drain("hor_active");

    // Reset in the middle of a PGT slot with a request still held
    ntb = 4'h1; pat_table = 10'h005; pat_name = 8'h41; num_line = 9'sd3;
    ctb = 8'hA5; pgb = 3'b110; opmode = OPMODE_GRAPH1; bus.cpu_addr_i = 14'h2A55;
    expect_slot(AC_PNT, 14'h0405);
    expect_slot(AC_PCT, {8'hA5, 1'b0, 5'h08});
    expect_slot(AC_PGT, {3'b110, 8'h41, 3'b011});
    step(1'b1); hor_active = 1'b1;
    step(1'b1);
    step(1'b1); bus.cpu_req_i = 1'b1;
    step(1'b0); rst = 1'b1;
    #1 check_reset_outputs("reset_mid_pgt");
    check("pending_after_abort", exp_q.size(), 0);
    step(1'b0);
    expect_slot(AC_PNT, 14'h0405);
    expect_slot(AC_PCT, {8'hA5, 1'b0, 5'h08});
    expect_slot(AC_PGT, {3'b110, 8'h41, 3'b011});
    expect_slot(AC_CPU, 14'h2A55);
    step(1'b1); rst = 1'b0;
    repeat (3) step(1'b1);
    step(1'b0); hor_active = 1'b0;
    drain("reset_recover");

    // MULTIC: two CPU slots when enabled, otherwise identical to GRAPH1
    ntb = 4'h7; pat_table = 10'h001; pat_name = 8'h33; num_line = 9'sd20;
    pgb = 3'b011; ctb = 8'h22;
    expect_slot(AC_PNT, 14'h1C01);
`ifdef VDP18_MULTIC_EN
    expect_slot(AC_PGT, {3'b011, 8'h33, 3'b101});
    expect_slot(AC_CPU, 14'h0111);
    expect_slot(AC_CPU, 14'h0222);
`else
    expect_slot(AC_PCT, {8'h22, 1'b0, 5'b00110});
    expect_slot(AC_PGT, {3'b011, 8'h33, 3'b100});
    expect_slot(AC_CPU, 14'h0222);
`endif
    step(1'b1); hor_active = 1'b1; opmode = OPMODE_MULTIC;
    step(1'b1);
    step(1'b1); bus.cpu_req_i = 1'b1; bus.cpu_addr_i = 14'h0111;
    step(1'b1); bus.cpu_req_i = 1'b1; bus.cpu_addr_i = 14'h0222;
    step(1'b0); hor_active = 1'b0;
    drain("multic");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
